traffic_injector: RTL and testbench

TRAFFIC_INJECTOR -- requirements
Module: traffic_injector

---
 rtl/traffic_injector.sv | 192 +++++++++++++++++++
 tb/tb_traffic_injector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_injector.sv
// Random traffic injector: LFSR-qualified packet generation into a descriptor queue,
// serialized as HEAD/BODY/TAIL flits. Define TRAFFIC_INJECTOR_STATS_EN for pkt/drop counters.
module traffic_injector #(
  parameter int LFSR_WIDTH    = 8,
  parameter int ID_WIDTH      = 6,
  parameter int TS_WIDTH      = 10,
  parameter int FLITS_PER_PKT = 4,
  parameter int QDEPTH        = 4,
  localparam int FW           = 2 + 2*ID_WIDTH + TS_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LFSR_WIDTH-1:0] rand_in,
  output logic                  rand_advance,
  input  logic [LFSR_WIDTH-1:0] rate,
  input  logic [ID_WIDTH-1:0]   src_id,
  output logic [FW-1:0]         flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic [15:0]           pkt_count,
  output logic [15:0]           drop_count
);

  localparam int DW = ID_WIDTH + TS_WIDTH;
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(QDEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  logic [1:0]          state_reg, state_next;
  logic [3:0]          idx_reg, idx_next;
  logic [FW-1:0]       flit_out_reg, flit_out_next;
  logic                flit_valid_reg, flit_valid_next;
  logic [TS_WIDTH-1:0] ts_reg;
  logic [DW-1:0]       fifo_mem [QDEPTH];
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]         count_reg, count_next;

  logic                inject, fifo_full, fifo_empty, transfer, pop, push;
  logic [ID_WIDTH-1:0] dest_raw, dest;
  logic [DW-1:0]       head_desc;
  logic [FW-1:0]       head_flit, tail_flit;

  assign rand_advance = enable;
  assign inject       = enable && (rand_in < rate);
  assign dest_raw     = rand_in[ID_WIDTH-1:0];
  // Never address ourselves: flip the LSB when the random destination hits src_id.
  assign dest         = (dest_raw == src_id) ? (src_id ^ ID_WIDTH'(1)) : dest_raw;

  assign fifo_full  = (count_reg == CNT_DEPTH);
  assign fifo_empty = (count_reg == '0);
  assign transfer   = flit_valid_reg && flit_ready;
  assign pop        = transfer && (state_reg == ST_HEAD);
  // A pop in the same cycle frees a slot, so a full queue still accepts the push.
  assign push       = inject && (!fifo_full || pop);

  assign head_desc = fifo_mem[rd_ptr_reg];
  assign head_flit = {2'b01, head_desc[DW-1 -: ID_WIDTH], src_id, head_desc[TS_WIDTH-1:0]};
  assign tail_flit = {2'b10, (FW-2)'(FLITS_PER_PKT-1)};

  assign flit_out   = flit_out_reg;
  assign flit_valid = flit_valid_reg;

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    flit_out_next   = flit_out_reg;
    flit_valid_next = flit_valid_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next      = ST_HEAD;
          flit_out_next   = head_flit;
          flit_valid_next = 1'b1;
        end
      end
      ST_HEAD: begin
        if (transfer) begin
          if (FLITS_PER_PKT == 2) begin
            state_next    = ST_TAIL;
            flit_out_next = tail_flit;
          end else begin
            state_next    = ST_BODY;
            idx_next      = 4'd1;
            flit_out_next = {2'b00, (FW-2)'(1)};
          end
        end
      end
      ST_BODY: begin
        if (transfer) begin
          if (idx_reg == 4'(FLITS_PER_PKT-2)) begin
            state_next    = ST_TAIL;
            flit_out_next = tail_flit;
          end else begin
            idx_next      = idx_reg + 4'd1;
            flit_out_next = {2'b00, (FW-2)'(idx_reg + 4'd1)};
          end
        end
      end
      default: begin
        if (transfer) begin
          if (!fifo_empty) begin
            state_next    = ST_HEAD;
            flit_out_next = head_flit;
          end else begin
            state_next      = ST_IDLE;
            flit_out_next   = '0;
            flit_valid_next = 1'b0;
          end
        end
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      flit_out_reg   <= '0;
      flit_valid_reg <= 1'b0;
      ts_reg         <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      flit_out_reg   <= flit_out_next;
      flit_valid_reg <= flit_valid_next;
      count_reg      <= count_next;
      if (enable) begin
        ts_reg <= ts_reg + TS_WIDTH'(1);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // Descriptor storage is left unreset; the pointers alone define its contents.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr_reg] <= {dest, ts_reg};
    end
  end

`ifdef TRAFFIC_INJECTOR_STATS_EN
  logic [15:0] pkt_count_reg, drop_count_reg;
  logic        pkt_done, drop;

  assign pkt_done = transfer && (state_reg == ST_TAIL);
  assign drop     = inject && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      if (pkt_done && (pkt_count_reg != 16'hFFFF)) begin
        pkt_count_reg <= pkt_count_reg + 16'd1;
      end
      if (drop && (drop_count_reg != 16'hFFFF)) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  assign pkt_count  = pkt_count_reg;
  assign drop_count = drop_count_reg;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_traffic_injector.sv
// Directed bench for traffic_injector: a default instance and a TS_WIDTH=4 / 2-flit instance
// share stimulus; expected flits are queued at injection and popped on each handshake.
module tb_traffic_injector;

  localparam int IW   = 6;
  localparam int TS1  = 10;
  localparam int FPP1 = 4;
  localparam int FW1  = 2 + 2*IW + TS1;
  localparam int TS2  = 4;
  localparam int FPP2 = 2;
  localparam int FW2  = 2 + 2*IW + TS2;

  logic           clock = 1'b0;
  logic           reset, enable, flit_ready;
  logic [7:0]     rand_in, rate;
  logic [IW-1:0]  src_id;
  logic           adv1, adv2, v1, v2;
  logic [FW1-1:0] flit1;
  logic [FW2-1:0] flit2;
  logic [15:0]    pc1, dc1, pc2, dc2;

  int n_cmp = 0;
  int n_err = 0;
  int ts_m = 0;
  int exp_pkts = 0;
  int exp_drops = 0;
  logic [FW1-1:0] q1[$];
  logic [FW2-1:0] q2[$];
  logic [FW1-1:0] h1;
  logic [FW2-1:0] h2;
  bit             h1_v = 0;
  bit             h2_v = 0;
  bit             found;

  always #5 clock = ~clock;

  traffic_injector u_dut1 (
    .clock(clock), .reset(reset), .enable(enable), .rand_in(rand_in),
    .rand_advance(adv1), .rate(rate), .src_id(src_id), .flit_out(flit1),
    .flit_valid(v1), .flit_ready(flit_ready), .pkt_count(pc1), .drop_count(dc1)
  );

  traffic_injector #(.TS_WIDTH(TS2), .FLITS_PER_PKT(FPP2)) u_dut2 (
    .clock(clock), .reset(reset), .enable(enable), .rand_in(rand_in),
    .rand_advance(adv2), .rate(rate), .src_id(src_id), .flit_out(flit2),
    .flit_valid(v2), .flit_ready(flit_ready), .pkt_count(pc2), .drop_count(dc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_pkt(input logic [7:0] r);
    logic [IW-1:0]  d;
    logic [TS1-1:0] t1;
    logic [TS2-1:0] t2;
    d  = (r[IW-1:0] == src_id) ? (src_id ^ 6'd1) : r[IW-1:0];
    t1 = TS1'(ts_m);
    t2 = TS2'(ts_m);
    q1.push_back({2'b01, d, src_id, t1});
    for (int i = 1; i <= FPP1-2; i++) q1.push_back({2'b00, (FW1-2)'(i)});
    q1.push_back({2'b10, (FW1-2)'(FPP1-1)});
    q2.push_back({2'b01, d, src_id, t2});
    q2.push_back({2'b10, (FW2-2)'(FPP2-1)});
  endtask

  // One enabled cycle with the given random word; drop marks an injection the queue must refuse.
  task automatic cycle(input logic [7:0] r, input bit drop);
    enable  = 1'b1;
    rand_in = r;
    if (r < rate) begin
      if (drop) begin
        exp_drops++;
      end else begin
        push_pkt(r);
        exp_pkts++;
      end
    end
    ts_m++;
    tick();
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    enable = 1'b0;
    while ((q1.size() != 0 || q2.size() != 0 || v1 || v2) && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_drain_in_budget"}, 32'(k < budget), 1);
  endtask

  task automatic check_counts(input string tag);
`ifdef TRAFFIC_INJECTOR_STATS_EN
    chk({tag, "_pkt1"}, pc1, exp_pkts);
    chk({tag, "_pkt2"}, pc2, exp_pkts);
    chk({tag, "_drop1"}, dc1, exp_drops);
    chk({tag, "_drop2"}, dc2, exp_drops);
`else
    chk({tag, "_pkt1"}, pc1, 0);
    chk({tag, "_pkt2"}, pc2, 0);
    chk({tag, "_drop1"}, dc1, 0);
    chk({tag, "_drop2"}, dc2, 0);
`endif
  endtask

  // Monitor: rand_advance follows enable, held flits stay stable, transfers match the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      chk("rand_advance1", adv1, enable);
      chk("rand_advance2", adv2, enable);
      if (reset) begin
        q1.delete();
        q2.delete();
        h1_v = 0;
        h2_v = 0;
      end else begin
        if (h1_v) chk("hold1", {v1, flit1}, {1'b1, h1});
        if (h2_v) chk("hold2", {v2, flit2}, {1'b1, h2});
        if (v1 && flit_ready) begin
          chk("flit1_expected", 32'(q1.size() != 0), 1);
          if (q1.size() != 0) chk("flit1", flit1, q1.pop_front());
        end
        if (v2 && flit_ready) begin
          chk("flit2_expected", 32'(q2.size() != 0), 1);
          if (q2.size() != 0) chk("flit2", flit2, q2.pop_front());
        end
        h1_v = v1 && !flit_ready;
        h1   = flit1;
        h2_v = v2 && !flit_ready;
        h2   = flit2;
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; flit_ready = 1'b1;
    rand_in = 8'h00; rate = 8'h00; src_id = 6'd5;
    repeat (3) tick();
    chk("reset_valid", {v1, v2}, 2'b00);
    chk("reset_flit1", flit1, 0);
    chk("reset_flit2", flit2, 0);
    chk("reset_counts", {pc1, dc1}, 0);
    reset = 1'b0;

    // rate 0 never injects
    for (int i = 0; i < 100; i++) begin
      cycle(8'($urandom_range(0, 255)), 0);
      chk("rate0_no_valid", 32'(v1 | v2), 0);
    end

    // self-addressed word remaps to src_id^1; HEAD one cycle after the push
    rate = 8'hFF;
    cycle(8'h05, 0);
    chk("head_not_yet", 32'(v1), 0);
    enable = 1'b0;
    tick();
    chk("head_valid", {v1, v2}, 2'b11);
    chk("head_dest", flit1[FW1-3 -: IW], 4);
    repeat (3) tick();
    chk("tail_after_3", {v1, flit1[FW1-1 -: 2]}, 3'b110);
    drain("single", 50);
    check_counts("single");

    // threshold boundaries and back-to-back packets
    rate = 8'h80;
    cycle(8'h7F, 0);
    cycle(8'h80, 0);
    cycle(8'h00, 0);
    cycle(8'h45, 0);
    rate = 8'hFF;
    cycle(8'hFF, 0);
    cycle(8'hC7, 0);
    drain("patterns", 100);
    check_counts("patterns");

    // stalled sink: four queue, two drop, outputs held
    flit_ready = 1'b0;
    for (int i = 0; i < 6; i++) cycle(8'h10 + 8'(i), i >= 4);
    enable = 1'b0;
    repeat (3) tick();
    chk("stall_head_held", {v1, flit1[FW1-1 -: 2]}, 3'b101);
    check_counts("stall");
    // push into a full queue alongside a HEAD pop: no drop
    flit_ready = 1'b1;
    cycle(8'h20, 0);
    drain("full_pushpop", 200);
    check_counts("full_pushpop");

    // reset during BODY flit 2 abandons the packet and wins over enable
    cycle(8'h33, 0);
    enable = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (v1 && flit1 == FW1'(2)) found = 1;
    end
    chk("reach_body2", 32'(found), 1);
    reset = 1'b1; enable = 1'b1; rand_in = 8'h01;
    tick();
    chk("midpkt_reset_valid", {v1, v2}, 2'b00);
    chk("midpkt_reset_counts", {pc1, dc1, pc2, dc2}, 0);
    reset = 1'b0; enable = 1'b0;
    ts_m = 0; exp_pkts = 0; exp_drops = 0;
    tick();
    chk("no_inject_in_reset", {v1, v2}, 2'b00);

    // 4-bit timestamp wraps after 17 enabled cycles
    rate = 8'h00;
    for (int i = 0; i < 17; i++) cycle(8'($urandom_range(0, 255)), 0);
    rate = 8'hFF;
    cycle(8'h2A, 0);
    enable = 1'b0;
    tick();
    chk("ts_wrap_head2", {v2, flit2[TS2-1:0]}, {1'b1, 4'd1});
    chk("ts_head1", {v1, flit1[TS1-1:0]}, {1'b1, 10'd17});
    drain("after_reset", 50);
    check_counts("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
